// File: rtl/scarv_cop_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scarv_cop_mem_arb                                                        |
// | Shares one data-memory port between the CPU (C) and coprocessor (X).     |
// | Zero added latency, fixed CPU priority with a starvation limit; define   |
// | SCARV_COP_MEM_ARB_RR_EN for round-robin contention instead.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scarv_cop_mem_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        c_cen,
    input  logic        c_wen,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_ben,
    output logic [31:0] c_rdata,
    output logic        c_stall,
    output logic        c_error,

    input  logic        x_cen,
    input  logic        x_wen,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    input  logic [3:0]  x_ben,
    output logic [31:0] x_rdata,
    output logic        x_stall,
    output logic        x_error,

    output logic        m_cen,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_ben,
    input  logic [31:0] m_rdata,
    input  logic        m_stall,
    input  logic        m_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_C = 2'd1;
    localparam logic [1:0] ST_OWN_X = 2'd2;

    logic [1:0] state_q, state_d;
    logic       p_cen_c_q, p_cen_c_d;
    logic       p_cen_x_q, p_cen_x_d;

    logic       w_own_c, w_own_x;
    logic       w_arb_en;
    logic       w_c_wins;
    logic       w_gnt_c, w_gnt_x;
    logic       w_fwd_c, w_fwd_x;

    always_comb begin
        w_own_c  = (state_q == ST_OWN_C);
        w_own_x  = (state_q == ST_OWN_X);
        // Arbitrate when idle or when the owner completes; reset blocks any grant
        // so m_cen drops in the same cycle reset is asserted.
        w_arb_en = g_resetn && (!(w_own_c || w_own_x) || !m_stall);
        w_gnt_c  = w_arb_en && c_cen && (!x_cen || w_c_wins);
        w_gnt_x  = w_arb_en && x_cen && (!c_cen || !w_c_wins);
        w_fwd_c  = w_gnt_c || (w_own_c && m_stall);
        w_fwd_x  = w_gnt_x || (w_own_x && m_stall);
    end

    always_comb begin
        state_d = state_q;
        if (w_arb_en) begin
            if (w_gnt_c) begin
                state_d = ST_OWN_C;
            end else if (w_gnt_x) begin
                state_d = ST_OWN_X;
            end else begin
                state_d = ST_IDLE;
            end
        end
        // A port is pending when it asked, was not granted and is not the stalled owner.
        p_cen_c_d = c_cen && !w_gnt_c && !(w_own_c && m_stall);
        p_cen_x_d = x_cen && !w_gnt_x && !(w_own_x && m_stall);
    end

`ifdef SCARV_COP_MEM_ARB_RR_EN
    logic last_x_q, last_x_d;

    assign w_c_wins = last_x_q;

    always_comb begin
        last_x_d = last_x_q;
        if (w_gnt_c && x_cen) begin
            last_x_d = 1'b0;
        end else if (w_gnt_x && c_cen) begin
            last_x_d = 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            last_x_q <= 1'b1;
        end else begin
            last_x_q <= last_x_d;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign w_c_wins = (starve_cnt_q != STARVE_MAX);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_gnt_x) begin
            starve_cnt_d = 4'd0;
        end else if (w_gnt_c && x_cen && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= ST_IDLE;
            p_cen_c_q <= 1'b0;
            p_cen_x_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_cen_c_q <= p_cen_c_d;
            p_cen_x_q <= p_cen_x_d;
        end
    end

    always_comb begin
        m_cen   = w_fwd_c || w_fwd_x;
        m_wen   = 1'b0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_ben   = 4'd0;
        if (w_fwd_c) begin
            m_wen   = c_wen;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            m_ben   = c_ben;
        end else if (w_fwd_x) begin
            m_wen   = x_wen;
            m_addr  = x_addr;
            m_wdata = x_wdata;
            m_ben   = x_ben;
        end
    end

    always_comb begin
        c_stall = w_own_c ? m_stall : p_cen_c_q;
        x_stall = w_own_x ? m_stall : p_cen_x_q;
        c_rdata = (w_own_c && !m_stall) ? m_rdata : 32'd0;
        x_rdata = (w_own_x && !m_stall) ? m_rdata : 32'd0;
        c_error = w_own_c && !m_stall && m_error;
        x_error = w_own_x && !m_stall && m_error;
    end

endmodule
`default_nettype wire
